// File: rtl/stream_demux4_pkg.sv
// rtl/stream_demux4_pkg.sv - shared state encoding for the stream buffer blocks
package stream_demux4_pkg;

  localparam logic [1:0] ST_EMPTY_ENC = 2'd0;
  localparam logic [1:0] ST_ONE_ENC   = 2'd1;
  localparam logic [1:0] ST_FULL_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = ST_EMPTY_ENC,
    ST_ONE   = ST_ONE_ENC,
    ST_FULL  = ST_FULL_ENC
  } buf_state_t;

endpackage

// File: rtl/stream_demux4_dec2to4.sv
// rtl/stream_demux4_dec2to4.sv - 2-bit index to one-hot 4-bit decoder
module stream_demux4_dec2to4 (
  input  logic [1:0] sel,
  output logic [3:0] onehot
);

  always_comb begin
    onehot = 4'b0000;
    case (sel)
      2'd0: onehot = 4'b0001;
      2'd1: onehot = 4'b0010;
      2'd2: onehot = 4'b0100;
      2'd3: onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
  end

endmodule

// File: rtl/stream_demux4.sv
// rtl/stream_demux4.sv - registered 1-to-4 stream demultiplexer with two-entry skid buffer
module stream_demux4
  import stream_demux4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [1:0]       s_sel,
  input  logic [WIDTH-1:0] s_data,
  output logic [3:0]       m_valid,
  input  logic [3:0]       m_ready,
  output logic [WIDTH-1:0] m_data
);

  buf_state_t       state;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic [1:0]       main_sel;
  logic [1:0]       skid_sel;
  logic [3:0]       sel_onehot;
  logic             accept;
  logic             out;

  stream_demux4_dec2to4 u_dec (
    .sel    (main_sel),
    .onehot (sel_onehot)
  );

  // s_ready depends on state only, so no m_ready reaches it combinationally
  assign s_ready = (state != ST_FULL) && !reset;
  assign m_valid = (state != ST_EMPTY) ? sel_onehot : 4'b0000;
  assign m_data  = main_data;
  assign accept  = s_valid && s_ready;
  assign out     = |(m_valid & m_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_EMPTY;
      main_data <= '0;
      main_sel  <= 2'd0;
      skid_data <= '0;
      skid_sel  <= 2'd0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            main_data <= s_data;
            main_sel  <= s_sel;
            state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && !out) begin
            skid_data <= s_data;
            skid_sel  <= s_sel;
            state     <= ST_FULL;
          end else if (accept && out) begin
            main_data <= s_data;
            main_sel  <= s_sel;
          end else if (out) begin
            state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out) begin
            main_data <= skid_data;
            main_sel  <= skid_sel;
            state     <= ST_ONE;
          end
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_demux4.sv
// tb/tb_stream_demux4.sv - scoreboard bench for stream_demux4 against a FIFO reference model
module tb_stream_demux4;

  typedef struct packed {
    logic [1:0] sel;
    logic [7:0] data;
  } word_t;

  logic       clk;
  logic       reset;
  logic       s_valid;
  logic       s_ready;
  logic [1:0] s_sel;
  logic [7:0] s_data;
  logic [3:0] m_valid;
  logic [3:0] m_ready;
  logic [7:0] m_data;

  int checks;
  int failures;

  // in_q: words accepted at the coming edge; mq: words the block should be holding
  word_t in_q[$];
  word_t mq[$];

  stream_demux4 #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_sel   (s_sel),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] d,
                       input logic [3:0] rdy, input logic rst);
    word_t w;
    @(posedge clk);
    #1;
    s_valid = v;
    s_sel   = sel;
    s_data  = d;
    m_ready = rdy;
    reset   = rst;
    #1;
    if (v && s_ready) begin
      w.sel  = sel;
      w.data = d;
      in_q.push_back(w);
    end
  endtask

  // Monitor: compares the DUT against the model, then retires outputs and admits inputs
  initial begin
    logic [3:0] exp_valid;
    logic       exp_ready;
    word_t      w;
    forever begin
      @(posedge clk);
      #4;
      exp_valid = (mq.size() > 0) ? (4'b0001 << mq[0].sel) : 4'b0000;
      exp_ready = !reset && (mq.size() < 2);
      check("m_valid", {28'd0, m_valid}, {28'd0, exp_valid});
      check("s_ready", {31'd0, s_ready}, {31'd0, exp_ready});
      if (mq.size() > 0)
        check("m_data", {24'd0, m_data}, {24'd0, mq[0].data});
      if (reset) begin
        mq.delete();
        in_q.delete();
      end else begin
        if (mq.size() > 0 && m_ready[mq[0].sel])
          void'(mq.pop_front());
        if (in_q.size() > 0) begin
          w = in_q.pop_front();
          mq.push_back(w);
        end
      end
    end
  end

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    s_sel   = 2'd0;
    s_data  = 8'd0;
    m_ready = 4'b0000;
    checks   = 0;
    failures = 0;

    repeat (3) drive(1'b1, 2'd0, 8'h00, 4'b1111, 1'b1);
    drive(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0);
    check("reset_m_data", {24'd0, m_data}, 32'd0);
    check("reset_s_ready_rise", {31'd0, s_ready}, 32'd1);

    // single word
    drive(1'b1, 2'd2, 8'hA5, 4'b1111, 1'b0);
    repeat (3) drive(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0);

    // streaming, sel cycling 0..3
    for (int i = 0; i < 8; i++)
      drive(1'b1, 2'(i % 4), 8'h10 + 8'(i), 4'b1111, 1'b0);
    repeat (3) drive(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0);

    // backpressure up to FULL, then release port 1 and port 3
    drive(1'b1, 2'd1, 8'h21, 4'b0000, 1'b0);
    drive(1'b1, 2'd3, 8'h22, 4'b0000, 1'b0);
    repeat (3) drive(1'b1, 2'd0, 8'hEE, 4'b0000, 1'b0);
    check("full_s_ready", {31'd0, s_ready}, 32'd0);
    drive(1'b0, 2'd0, 8'h00, 4'b0010, 1'b0);
    repeat (3) drive(1'b0, 2'd0, 8'h00, 4'b0111, 1'b0);
    drive(1'b0, 2'd0, 8'h00, 4'b1000, 1'b0);
    repeat (2) drive(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);

    // ready only on the wrong ports
    drive(1'b1, 2'd0, 8'h33, 4'b1110, 1'b0);
    repeat (5) drive(1'b0, 2'd0, 8'h00, 4'b1110, 1'b0);
    drive(1'b0, 2'd0, 8'h00, 4'b0001, 1'b0);
    repeat (2) drive(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0);

    // reset while FULL discards both words
    drive(1'b1, 2'd2, 8'h44, 4'b0000, 1'b0);
    drive(1'b1, 2'd1, 8'h45, 4'b0000, 1'b0);
    drive(1'b1, 2'd3, 8'h46, 4'b0000, 1'b1);
    drive(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0);
    check("post_reset_s_ready", {31'd0, s_ready}, 32'd1);
    repeat (3) drive(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0);

    // randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      logic [3:0] rdy;
      rdy = 4'($urandom) | 4'($urandom);
      if ($urandom_range(0, 9) == 0) rdy = 4'b0000;
      drive(($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), rdy,
            ($urandom_range(0, 99) == 0));
    end

    repeat (6) drive(1'b0, 2'd0, 8'h00, 4'b1111, 1'b0);
    check("drain_mq_empty", mq.size(), 32'd0);
    check("drain_in_q_empty", in_q.size(), 32'd0);
    check("drain_m_valid", {28'd0, m_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_demux4.md
Name: stream_demux4

Overview:
- Registered 1-to-4 stream demultiplexer; the distributing counterpart to the team's mux2/mux4/mux8 selectors.
- Accepts one valid/ready input stream tagged with a 2-bit destination select and delivers each word to exactly one of four valid/ready output ports.
- Two-entry skid buffer gives full throughput with no combinational path from any m_ready to s_ready.
- Used to route write-back and monitor traffic from a single producer to one of four consumers.

Parameters:
- WIDTH, 8, data word width in bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- s_valid  input  1  input word present.
- s_ready  output  1  block can accept an input word this cycle.
- s_sel  input  2  destination port index (0..3), qualified by s_valid.
- s_data  input  WIDTH  input word.
- m_valid  output  4  one-hot (or zero) valid, bit i for port i.
- m_ready  input  4  per-port ready.
- m_data  output  WIDTH  shared output data bus, meaningful only where m_valid is nonzero.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Transfer definitions:
  - Input accept: s_valid & s_ready at a rising edge.
  - Output transfer: m_valid[i] & m_ready[i] at a rising edge.
- Internal storage:
  - Main register: main_data, main_sel.
  - Skid register: skid_data, skid_sel.
  - State register: EMPTY, ONE (main occupied), FULL (main + skid occupied).
- Output and ready equations:
  - m_valid = (state != EMPTY) ? onehot(main_sel) : 4'b0000.
  - m_data = main_data.
  - s_ready = (state != FULL) & ~reset, decoded from state only.
- Transitions:
  - EMPTY + accept -> ONE, main <= input.
  - ONE + accept & !out -> FULL, skid <= input.
  - ONE + accept & out -> ONE, main <= input.
  - ONE + out & !accept -> EMPTY.
  - FULL + out -> ONE, main <= skid. No accept is possible, since s_ready = 0.
- Latency: 1 cycle from input accept to m_valid, when the block was EMPTY.
- Throughput: sustained 1 word/cycle while the selected m_ready stays high.
- Ordering: strict FIFO order across all ports. A stalled destination blocks the words behind it (head-of-line blocking by design).
- Stability: while m_valid[i] = 1 and m_ready[i] = 0, m_valid and m_data hold constant.
- m_ready of non-selected ports is ignored.
- s_sel and s_data are sampled only on accept; values are don't-care otherwise.
- Reset values: state = EMPTY, m_valid = 0, s_ready = 0 during reset, main/skid data = 0.
- Reset mid-operation: all buffered words are discarded. s_ready rises the first cycle after reset deasserts.
- No X propagation: m_data = 0 after reset until the first load.

Decomposition:
- Shared header: state encodings (EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2) as localparams in a common include for all stream blocks.
- Sub-module: dec2to4 (2-bit to one-hot 4-bit decoder), the decoder counterpart to mux4. Reused for m_valid generation.

Test Plan:
- Single word: after reset, s_sel=2, s_data=8'hA5, one cycle, m_ready=4'b1111 -> next cycle m_valid=4'b0100, m_data=8'hA5; the cycle after, m_valid=0.
- Streaming: 8 back-to-back words 0x10..0x17 with s_sel cycling 0,1,2,3, m_ready all 1 -> s_ready stays 1 throughout; words emerge in order with m_valid 0001, 0010, 0100, 1000 repeating, one per cycle.
- Backpressure: m_ready=0 while sending 0x21 (sel 1) and 0x22 (sel 3) -> state FULL, s_ready=0; m_valid=0010 with m_data=0x21 held. Raise m_ready[1] -> 0x21 out, then m_valid=1000 with m_data=0x22 held until m_ready[3].
- Wrong-port ready: word for sel 0 with m_ready=4'b1110 -> m_valid=0001 persists indefinitely and no transfer occurs; set m_ready[0]=1 -> delivered next edge.
- Simultaneous accept and out in ONE: s_valid each cycle, destination ready -> state stays ONE and no data lost; scoreboard matches input sequence exactly.
- Mid-operation reset: state FULL, assert reset one cycle -> m_valid=0 and s_ready=0 that cycle; after deassert, s_ready=1 and the old words never appear.
